// File: rtl/active_device_tracker_if.sv
// Event/status bundle between the device event decoder and the tracker.
// The master drives events and peak clear; the slave (tracker) drives status.
interface active_device_tracker_if #(
    parameter int N_DEV = 16,
    parameter int ID_W  = 4,
    parameter int WIDTH = 8
);
    logic             change;
    logic             on_off;
    logic [ID_W-1:0]  dev_id;
    logic             peak_clr;
    logic [WIDTH-1:0] counter_out;
    logic [WIDTH-1:0] peak_out;
    logic [N_DEV-1:0] active_map;
    logic             alarm;
    logic             ignored;

    modport master (
        output change, on_off, dev_id, peak_clr,
        input  counter_out, peak_out, active_map, alarm, ignored
    );

    modport slave (
        input  change, on_off, dev_id, peak_clr,
        output counter_out, peak_out, active_map, alarm, ignored
    );
endinterface

// File: rtl/active_device_tracker.sv
// Per-device on/off bitmap with duplicate filtering, active count,
// clearable high-water mark and a hysteresis occupancy alarm.
// All outputs are registered; one cycle from event to status.
//
// Alarm state machine:
//   state    | meaning
//   ST_IDLE  | occupancy below set threshold, alarm low
//   ST_ALARM | occupancy reached ALARM_HI, held until count <= ALARM_LO
module active_device_tracker #(
    parameter int N_DEV    = 16,
    parameter int ID_W     = 4,
    parameter int WIDTH    = 8,
    parameter int ALARM_HI = 12,
    parameter int ALARM_LO = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    active_device_tracker_if.slave  bus
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ALARM = 1'b1
    } alarm_state_t;

    // One extra bit so the range check also works when N_DEV == 2^ID_W.
    localparam logic [ID_W:0]    LP_N_DEV = (ID_W+1)'(N_DEV);
    localparam logic [N_DEV-1:0] LP_ONE   = N_DEV'(1);
    localparam logic [WIDTH-1:0] LP_HI    = WIDTH'(ALARM_HI);
    localparam logic [WIDTH-1:0] LP_LO    = WIDTH'(ALARM_LO);
    localparam logic [WIDTH-1:0] LP_INC   = WIDTH'(1);

    logic [N_DEV-1:0] r_map;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_peak;
    logic             r_ignored;
    alarm_state_t     r_state;
    logic             r_alarm;

    logic             w_id_valid;
    logic [N_DEV-1:0] w_sel;
    logic             w_cur;
    logic             w_set;
    logic             w_clr;
    logic             w_reject;
    logic [N_DEV-1:0] w_map_next;
    logic [WIDTH-1:0] w_cnt_next;

    // Event classification and next map/count; an out-of-range id decodes to an empty select.
    always_comb begin
        w_id_valid = ({1'b0, bus.dev_id} < LP_N_DEV);
        w_sel      = LP_ONE << bus.dev_id;
        w_cur      = |(r_map & w_sel);
        w_set      = bus.change && w_id_valid &&  bus.on_off && !w_cur;
        w_clr      = bus.change && w_id_valid && !bus.on_off &&  w_cur;
        w_reject   = bus.change && !w_set && !w_clr;
        w_map_next = r_map;
        w_cnt_next = r_cnt;
        if (w_set) begin
            w_map_next = r_map | w_sel;
            w_cnt_next = r_cnt + LP_INC;
        end else if (w_clr) begin
            w_map_next = r_map & ~w_sel;
            w_cnt_next = r_cnt - LP_INC;
        end
    end

    // Map, count, rejection pulse and high-water mark.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_map     <= '0;
            r_cnt     <= '0;
            r_peak    <= '0;
            r_ignored <= 1'b0;
        end else begin
            r_map     <= w_map_next;
            r_cnt     <= w_cnt_next;
            r_ignored <= w_reject;
            if (bus.peak_clr || (w_cnt_next > r_peak)) begin
                r_peak <= w_cnt_next;
            end
        end
    end

    // Hysteresis alarm, evaluated on the count being registered this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_alarm <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_cnt_next >= LP_HI) begin
                        r_state <= ST_ALARM;
                        r_alarm <= 1'b1;
                    end
                end
                ST_ALARM: begin
                    if (w_cnt_next <= LP_LO) begin
                        r_state <= ST_IDLE;
                        r_alarm <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_alarm <= 1'b0;
                end
            endcase
        end
    end

    assign bus.counter_out = r_cnt;
    assign bus.peak_out    = r_peak;
    assign bus.active_map  = r_map;
    assign bus.alarm       = r_alarm;
    assign bus.ignored     = r_ignored;

endmodule

// File: tb/tb_active_device_tracker.sv
// Bench for active_device_tracker: a default instance (16 devices) and a
// 12-device instance share one stimulus stream; both are checked against
// a bitmap/popcount reference model, plus table vectors and directed cases.
module tb_active_device_tracker;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    active_device_tracker_if #(.N_DEV(16), .ID_W(4), .WIDTH(8)) ifa ();
    active_device_tracker_if #(.N_DEV(12), .ID_W(4), .WIDTH(8)) ifb ();

    active_device_tracker #(
        .N_DEV(16), .ID_W(4), .WIDTH(8), .ALARM_HI(12), .ALARM_LO(8)
    ) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    active_device_tracker #(
        .N_DEV(12), .ID_W(4), .WIDTH(8), .ALARM_HI(12), .ALARM_LO(8)
    ) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state, index 0 = default instance, 1 = 12-device instance.
    bit m_map   [2][16];
    int m_cnt   [2];
    int m_peak  [2];
    bit m_alarm [2];
    bit m_ign   [2];
    int m_ndev  [2] = '{16, 12};

    typedef struct {
        bit r;
        bit ch;
        bit oo;
        int id;
        bit pc;
        int e_cnt;
        bit e_ign;
        int e_map;
        int e_peak;
        bit e_alarm;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    function automatic int model_map(input int k);
        int v = 0;
        for (int i = 0; i < m_ndev[k]; i++) begin
            if (m_map[k][i]) v += (1 << i);
        end
        return v;
    endfunction

    task automatic model_update(input bit r, input bit ch, input bit oo, input int id, input bit pc);
        for (int k = 0; k < 2; k++) begin
            if (r) begin
                for (int i = 0; i < 16; i++) m_map[k][i] = 1'b0;
                m_cnt[k]   = 0;
                m_peak[k]  = 0;
                m_alarm[k] = 1'b0;
                m_ign[k]   = 1'b0;
            end else begin
                m_ign[k] = 1'b0;
                if (ch) begin
                    if (id >= m_ndev[k])             m_ign[k] = 1'b1;
                    else if (m_map[k][id] == oo)     m_ign[k] = 1'b1;
                    else                             m_map[k][id] = oo;
                end
                m_cnt[k] = 0;
                for (int i = 0; i < m_ndev[k]; i++) m_cnt[k] += int'(m_map[k][i]);
                if (pc || m_cnt[k] > m_peak[k]) m_peak[k] = m_cnt[k];
                if (m_cnt[k] >= 12)     m_alarm[k] = 1'b1;
                else if (m_cnt[k] <= 8) m_alarm[k] = 1'b0;
            end
        end
    endtask

    task automatic model_check();
        chk("A.counter_out", int'(ifa.counter_out), m_cnt[0]);
        chk("A.peak_out",    int'(ifa.peak_out),    m_peak[0]);
        chk("A.active_map",  int'(ifa.active_map),  model_map(0));
        chk("A.alarm",       int'(ifa.alarm),       int'(m_alarm[0]));
        chk("A.ignored",     int'(ifa.ignored),     int'(m_ign[0]));
        chk("B.counter_out", int'(ifb.counter_out), m_cnt[1]);
        chk("B.peak_out",    int'(ifb.peak_out),    m_peak[1]);
        chk("B.active_map",  int'(ifb.active_map),  model_map(1));
        chk("B.alarm",       int'(ifb.alarm),       int'(m_alarm[1]));
        chk("B.ignored",     int'(ifb.ignored),     int'(m_ign[1]));
    endtask

    // Drive one cycle of stimulus to both instances, clock it, sample #1 later.
    task automatic step(input bit r, input bit ch, input bit oo, input int id, input bit pc);
        rst          = r;
        ifa.change   = ch;  ifb.change   = ch;
        ifa.on_off   = oo;  ifb.on_off   = oo;
        ifa.dev_id   = 4'(id); ifb.dev_id = 4'(id);
        ifa.peak_clr = pc;  ifb.peak_clr = pc;
        @(posedge clk);
        model_update(r, ch, oo, id, pc);
        #1;
        model_check();
    endtask

    initial begin
        // reset held two cycles with an on(3) event pending, then duplicate filtering on device 5
        tbl[0] = '{r:1, ch:1, oo:1, id:3, pc:0, e_cnt:0, e_ign:0, e_map:'h0000, e_peak:0, e_alarm:0};
        tbl[1] = '{r:1, ch:1, oo:1, id:3, pc:0, e_cnt:0, e_ign:0, e_map:'h0000, e_peak:0, e_alarm:0};
        tbl[2] = '{r:0, ch:1, oo:1, id:5, pc:0, e_cnt:1, e_ign:0, e_map:'h0020, e_peak:1, e_alarm:0};
        tbl[3] = '{r:0, ch:1, oo:1, id:5, pc:0, e_cnt:1, e_ign:1, e_map:'h0020, e_peak:1, e_alarm:0};
        tbl[4] = '{r:0, ch:1, oo:0, id:5, pc:0, e_cnt:0, e_ign:0, e_map:'h0000, e_peak:1, e_alarm:0};
        tbl[5] = '{r:0, ch:1, oo:0, id:5, pc:0, e_cnt:0, e_ign:1, e_map:'h0000, e_peak:1, e_alarm:0};

        rst = 1'b1;
        ifa.change = 1'b0; ifa.on_off = 1'b0; ifa.dev_id = '0; ifa.peak_clr = 1'b0;
        ifb.change = 1'b0; ifb.on_off = 1'b0; ifb.dev_id = '0; ifb.peak_clr = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_peak[i] = 0; m_alarm[i] = 1'b0; m_ign[i] = 1'b0;
            for (int j = 0; j < 16; j++) m_map[i][j] = 1'b0;
        end

        for (int i = 0; i < 6; i++) begin
            step(tbl[i].r, tbl[i].ch, tbl[i].oo, tbl[i].id, tbl[i].pc);
            chk($sformatf("tbl[%0d].counter_out", i), int'(ifa.counter_out), tbl[i].e_cnt);
            chk($sformatf("tbl[%0d].ignored", i),     int'(ifa.ignored),     int'(tbl[i].e_ign));
            chk($sformatf("tbl[%0d].active_map", i),  int'(ifa.active_map),  tbl[i].e_map);
            chk($sformatf("tbl[%0d].peak_out", i),    int'(ifa.peak_out),    tbl[i].e_peak);
            chk($sformatf("tbl[%0d].alarm", i),       int'(ifa.alarm),       int'(tbl[i].e_alarm));
        end

        // out-of-range id on the 12-device instance
        step(0, 1, 1, 2, 0);
        step(0, 1, 1, 13, 0);
        chk("inv.ignored",     int'(ifb.ignored),     1);
        chk("inv.counter_out", int'(ifb.counter_out), 1);
        chk("inv.active_map",  int'(ifb.active_map),  'h004);
        step(0, 0, 0, 0, 0);
        chk("inv.ignored_drop", int'(ifb.ignored), 0);

        // alarm hysteresis
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            step(0, 1, 1, i, 0);
            chk($sformatf("hi.alarm@%0d", i + 1), int'(ifa.alarm), (i == 11) ? 1 : 0);
        end
        for (int i = 11; i >= 4; i--) begin
            step(0, 1, 0, i, 0);
            chk($sformatf("lo.counter@%0d", i), int'(ifa.counter_out), i);
            chk($sformatf("lo.alarm@%0d", i),   int'(ifa.alarm), (i > 8) ? 1 : 0);
        end

        // peak hold and clear
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 1, 1, i, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 1, 0);
        chk("peak.count4", int'(ifa.counter_out), 4);
        chk("peak.hold6",  int'(ifa.peak_out),    6);
        step(0, 1, 1, 0, 1);
        chk("peak.clr5",   int'(ifa.peak_out),    5);

        // reset mid-operation with a concurrent event
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 1, 1, i, 0);
        chk("mid.pre_count", int'(ifa.counter_out), 7);
        chk("mid.pre_alarm", int'(ifa.alarm),       0);
        step(1, 1, 1, 9, 0);
        chk("mid.rst_count", int'(ifa.counter_out), 0);
        chk("mid.rst_map",   int'(ifa.active_map),  0);
        chk("mid.rst_peak",  int'(ifa.peak_out),    0);
        chk("mid.rst_alarm", int'(ifa.alarm),       0);
        chk("mid.rst_ign",   int'(ifa.ignored),     0);
        step(0, 1, 1, 9, 0);
        chk("mid.post_count", int'(ifa.counter_out), 1);
        chk("mid.post_map",   int'(ifa.active_map),  'h0200);

        // randomized traffic biased toward a busy population so the alarm toggles
        for (int n = 0; n < 3000; n++) begin
            bit r, ch, oo, pc;
            int id;
            r  = ($urandom_range(0, 199) == 0);
            ch = ($urandom_range(0, 3) != 0);
            oo = ($urandom_range(0, 99) < ((n / 300) % 2 == 0 ? 70 : 35));
            id = $urandom_range(0, 15);
            pc = ($urandom_range(0, 15) == 0);
            step(r, ch, oo, id, pc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
